hazard_ctrl: RTL and testbench

//  Pipeline hazard controller for the 5-stage core (F/D/E/M/W).
//  - Keeps shadow copies of destination register and Tnew for the E, M and W stages.
//  - Compares them against the D-stage Tuse to raise a stall.
//  - Generates forwarding selects for the D and E stages.
//  - Owns the Tnew saturating-decrement rule applied at each stage boundary.
//  - Drives enable/clear of the FD/DE/EM pipeline registers.

---
 rtl/hazard_pkg.sv | 20 ++
 rtl/hazard_ctrl_mdu_busy_ctr.sv | 32 +++
 rtl/hazard_ctrl.sv | 118 +++++++++++
 tb/tb_hazard_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared constants and helpers for the pipeline hazard controller
package hazard_pkg;

    // Tuse code meaning the operand is not read at all
    localparam logic [2:0] TUSE_NONE = 3'd7;

    // Forwarding source codes
    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_E  = 2'd1,
        FWD_M  = 2'd2,
        FWD_W  = 2'd3
    } fwd_t;

    // Tnew as seen one stage later: counts down, never below zero
    function automatic logic [2:0] sat_dec(input logic [2:0] t);
        return (t != 3'd0) ? t - 3'd1 : 3'd0;
    endfunction

endpackage

// File: rtl/hazard_ctrl_mdu_busy_ctr.sv
// mdu_busy_ctr: MDU busy tracker, loads the op latency on start and counts down
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-low reset, aborts any count
//   start  in   mult/div is in E this cycle
//   div    in   with start: 1 = div, 0 = mult
//   busy   out  start | (count != 0)
module mdu_busy_ctr #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic div,
    output logic busy
);
    localparam int CW = $clog2(((MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES) + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (start)
            count <= div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        else if (count != '0)
            count <= count - CW'(1);
    end

    assign busy = start | (count != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall and forwarding control for the 5-stage F/D/E/M/W core
//   clk, reset (async active-low)
//   D-stage in:  rs_d, rt_d, tuse_rs_d, tuse_rt_d, dst_d, tnew_d, md_d, md_div_d, md_use_d
//   out:         stall, fd_en, de_clr, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, md_busy
//   HAZ_MDU_EN defined: MDU busy counter and HI/LO stall; otherwise md_* are ignored.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs_d,
    input  logic [4:0] rt_d,
    input  logic [2:0] tuse_rs_d,
    input  logic [2:0] tuse_rt_d,
    input  logic [4:0] dst_d,
    input  logic [2:0] tnew_d,
    input  logic       md_d,
    input  logic       md_div_d,
    input  logic       md_use_d,
    output logic       stall,
    output logic       fd_en,
    output logic       de_clr,
    output logic [1:0] fwd_rs_d,
    output logic [1:0] fwd_rt_d,
    output logic [1:0] fwd_rs_e,
    output logic [1:0] fwd_rt_e,
    output logic       md_busy
);
    logic [4:0] dst_e, dst_m, dst_w, rs_e, rt_e;
    logic [2:0] tnew_e, tnew_m;
    logic       md_stall;

    function automatic logic hit(input logic [4:0] r, input logic [2:0] tuse,
                                 input logic [4:0] dst, input logic [2:0] tnew);
        return (r != 5'd0) && (dst == r) && (tuse != TUSE_NONE) && (tuse < tnew);
    endfunction

    // Youngest matching stage decides; a not-yet-ready match hides older copies
    function automatic fwd_t pick_d(input logic [4:0] r, e, m, w, input logic [2:0] te, tm);
        return (r == 5'd0) ? FWD_RF :
               (r == e)    ? ((te == 3'd0) ? FWD_E : FWD_RF) :
               (r == m)    ? ((tm == 3'd0) ? FWD_M : FWD_RF) :
               (r == w)    ? FWD_W : FWD_RF;
    endfunction

    function automatic fwd_t pick_e(input logic [4:0] r, m, w);
        return (r == 5'd0) ? FWD_RF : (r == m) ? FWD_M : (r == w) ? FWD_W : FWD_RF;
    endfunction

    assign stall = hit(rs_d, tuse_rs_d, dst_e, tnew_e) | hit(rs_d, tuse_rs_d, dst_m, tnew_m)
                 | hit(rt_d, tuse_rt_d, dst_e, tnew_e) | hit(rt_d, tuse_rt_d, dst_m, tnew_m)
                 | md_stall;
    assign fd_en  = ~stall;
    assign de_clr = stall;

    assign fwd_rs_d = pick_d(rs_d, dst_e, dst_m, dst_w, tnew_e, tnew_m);
    assign fwd_rt_d = pick_d(rt_d, dst_e, dst_m, dst_w, tnew_e, tnew_m);
    assign fwd_rs_e = pick_e(rs_e, dst_m, dst_w);
    assign fwd_rt_e = pick_e(rt_e, dst_m, dst_w);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dst_e  <= '0;
            tnew_e <= '0;
            rs_e   <= '0;
            rt_e   <= '0;
            dst_m  <= '0;
            tnew_m <= '0;
            dst_w  <= '0;
        end else begin
            dst_e  <= stall ? 5'd0 : dst_d;
            tnew_e <= stall ? 3'd0 : tnew_d;
            rs_e   <= stall ? 5'd0 : rs_d;
            rt_e   <= stall ? 5'd0 : rt_d;
            dst_m  <= dst_e;
            tnew_m <= sat_dec(tnew_e);
            dst_w  <= dst_m;
        end
    end

`ifdef HAZ_MDU_EN
    logic md_e, md_div_e;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_e     <= 1'b0;
            md_div_e <= 1'b0;
        end else begin
            md_e     <= ~stall & md_d;
            md_div_e <= md_div_d;
        end
    end

    mdu_busy_ctr #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_mdu (
        .clk  (clk),
        .reset(reset),
        .start(md_e),
        .div  (md_div_e),
        .busy (md_busy)
    );

    // HI/LO users and new MDU starts wait for the running operation
    assign md_stall = (md_d | md_use_d) & md_busy;
`else
    logic unused_md;
    localparam int unused_cycles = MULT_CYCLES + DIV_CYCLES;
    assign unused_md = md_d ^ md_div_d ^ md_use_d;
    assign md_busy   = 1'b0;
    assign md_stall  = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and randomized checks of hazard_ctrl against a pipeline model
module tb_hazard_ctrl;
    localparam int MULT = 5;
    localparam int DIV  = 10;
    localparam int TN   = 7;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] rs_d, rt_d, dst_d;
    logic [2:0] tuse_rs_d, tuse_rt_d, tnew_d;
    logic       md_d, md_div_d, md_use_d;
    logic       stall, fd_en, de_clr, md_busy;
    logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

    int errors = 0;
    int checks = 0;

    // Model: slot 0/1/2 = instruction now in E/M/W, tnew kept as at E entry
    int m_dst[3];
    int m_tnew[3];
    int m_rs, m_rt;
    int busy_end;
    int cyc;

    hazard_ctrl dut (
        .clk(clk), .reset(reset),
        .rs_d(rs_d), .rt_d(rt_d), .tuse_rs_d(tuse_rs_d), .tuse_rt_d(tuse_rt_d),
        .dst_d(dst_d), .tnew_d(tnew_d), .md_d(md_d), .md_div_d(md_div_d), .md_use_d(md_use_d),
        .stall(stall), .fd_en(fd_en), .de_clr(de_clr),
        .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d), .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e),
        .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    function automatic int tn(int k);
        return (m_tnew[k] > k) ? m_tnew[k] - k : 0;
    endfunction

    function automatic bit exp_busy();
`ifdef HAZ_MDU_EN
        return cyc <= busy_end;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit hit(int r, int tuse);
        for (int k = 0; k < 2; k++)
            if (r != 0 && m_dst[k] == r && tuse != TN && tuse < tn(k)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit exp_stall();
        return hit(int'(rs_d), int'(tuse_rs_d)) || hit(int'(rt_d), int'(tuse_rt_d))
            || ((md_d || md_use_d) && exp_busy());
    endfunction

    function automatic int exp_fwd_d(int r);
        if (r == 0) return 0;
        for (int k = 0; k < 3; k++)
            if (m_dst[k] == r) return (k == 2 || tn(k) == 0) ? k + 1 : 0;
        return 0;
    endfunction

    function automatic int exp_fwd_e(int r);
        if (r == 0) return 0;
        for (int k = 1; k < 3; k++)
            if (m_dst[k] == r) return k + 1;
        return 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_dst[k]  = 0;
            m_tnew[k] = 0;
        end
        m_rs = 0;
        m_rt = 0;
        busy_end = -1;
        cyc = 0;
    endtask

    task automatic set_d(input int rs, rt, trs, trt, dst, tnew, input bit md, dv, mu);
        rs_d = 5'(rs); rt_d = 5'(rt); tuse_rs_d = 3'(trs); tuse_rt_d = 3'(trt);
        dst_d = 5'(dst); tnew_d = 3'(tnew); md_d = md; md_div_d = dv; md_use_d = mu;
        @(negedge clk);
    endtask

    task automatic tick();
        bit s;
        s = exp_stall();
        @(posedge clk);
        for (int k = 2; k > 0; k--) begin
            m_dst[k]  = m_dst[k-1];
            m_tnew[k] = m_tnew[k-1];
        end
        m_dst[0]  = s ? 0 : int'(dst_d);
        m_tnew[0] = s ? 0 : int'(tnew_d);
        m_rs      = s ? 0 : int'(rs_d);
        m_rt      = s ? 0 : int'(rt_d);
`ifdef HAZ_MDU_EN
        if (!s && md_d) busy_end = cyc + 1 + (md_div_d ? DIV : MULT);
`endif
        cyc++;
        #1;
    endtask

    task automatic nop();
        set_d(0, 0, TN, TN, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        set_d(3, 1, 0, 0, 2, 3, 0, 0, 0);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
        checks++; if (fd_en !== 1'b1) begin errors++; $display("FAIL reset_fd_en: got %b want 1", fd_en); end
        checks++; if (de_clr !== 1'b0) begin errors++; $display("FAIL reset_de_clr: got %b want 0", de_clr); end
        checks++; if (fwd_rs_d !== 2'd0) begin errors++; $display("FAIL reset_fwd_rs_d: got %0d want 0", fwd_rs_d); end
        checks++; if (fwd_rt_d !== 2'd0) begin errors++; $display("FAIL reset_fwd_rt_d: got %0d want 0", fwd_rt_d); end
        checks++; if (fwd_rs_e !== 2'd0) begin errors++; $display("FAIL reset_fwd_rs_e: got %0d want 0", fwd_rs_e); end
        checks++; if (fwd_rt_e !== 2'd0) begin errors++; $display("FAIL reset_fwd_rt_e: got %0d want 0", fwd_rt_e); end
        checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL reset_md_busy: got %b want 0", md_busy); end
        nop();
        reset = 1'b1;
        model_reset();
        tick();
    endtask

    task automatic test_load_use();
        set_d(0, 0, TN, TN, 1, 2, 0, 0, 0);
        tick();
        set_d(1, 0, 1, TN, 4, 1, 0, 0, 0);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lw_stall: got %b want 1", stall); end
        checks++; if (de_clr !== 1'b1) begin errors++; $display("FAIL lw_de_clr: got %b want 1", de_clr); end
        tick();
        @(negedge clk);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lw_release: got %b want 0", stall); end
        tick();
        nop();
        checks++; if (fwd_rs_e !== 2'd3) begin errors++; $display("FAIL lw_fwd_rs_e: got %0d want 3", fwd_rs_e); end
        tick();
    endtask

    task automatic test_alu_branch();
        set_d(0, 0, TN, TN, 2, 1, 0, 0, 0);
        tick();
        set_d(2, 0, 0, TN, 0, 0, 0, 0, 0);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL beq_stall: got %b want 1", stall); end
        tick();
        @(negedge clk);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL beq_release: got %b want 0", stall); end
        checks++; if (fwd_rs_d !== 2'd2) begin errors++; $display("FAIL beq_fwd_rs_d: got %0d want 2", fwd_rs_d); end
        tick();
    endtask

    task automatic test_zero_reg();
        set_d(0, 0, TN, TN, 0, 3, 0, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            set_d(0, 0, 0, 0, 0, 0, 0, 0, 0);
            checks++; if (stall !== 1'b0) begin errors++; $display("FAIL zero_stall: got %b want 0", stall); end
            checks++; if (fwd_rs_d !== 2'd0) begin errors++; $display("FAIL zero_fwd_rs_d: got %0d want 0", fwd_rs_d); end
            checks++; if (fwd_rt_e !== 2'd0) begin errors++; $display("FAIL zero_fwd_rt_e: got %0d want 0", fwd_rt_e); end
            tick();
        end
    endtask

    task automatic test_e_wins();
        set_d(0, 0, TN, TN, 3, 0, 0, 0, 0);
        tick();
        set_d(0, 0, TN, TN, 3, 0, 0, 0, 0);
        tick();
        set_d(0, 3, TN, 1, 0, 0, 0, 0, 0);
        checks++; if (fwd_rt_d !== 2'd1) begin errors++; $display("FAIL e_wins_fwd_rt_d: got %0d want 1", fwd_rt_d); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL e_wins_stall: got %b want 0", stall); end
        tick();
    endtask

    task automatic test_mdu();
        int n, want, bw;
`ifdef HAZ_MDU_EN
        want = DIV + 1;
        bw = 1;
`else
        want = 0;
        bw = 0;
`endif
        set_d(0, 0, TN, TN, 0, 0, 1, 1, 0);
        tick();
        set_d(0, 0, TN, TN, 5, 1, 0, 0, 1);
        n = 0;
        while (stall === 1'b1 && n < 40) begin
            n++;
            tick();
            @(negedge clk);
        end
        checks++; if (n !== want) begin errors++; $display("FAIL div_stall_cycles: got %0d want %0d", n, want); end
        tick();
        set_d(0, 0, TN, TN, 0, 0, 1, 0, 0);
        tick();
        nop();
        tick();
        nop();
        checks++; if (md_busy !== 1'(bw)) begin errors++; $display("FAIL mult_busy: got %b want %0d", md_busy, bw); end
        reset = 1'b0;
        #1;
        checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL reset_abort_busy: got %b want 0", md_busy); end
        #1;
        reset = 1'b1;
        model_reset();
        tick();
        nop();
        checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b want 0", md_busy); end
        tick();
    endtask

    task automatic test_random();
        int t[4];
        t = '{0, 1, 2, TN};
        for (int i = 0; i < 600; i++) begin
            set_d($urandom_range(0, 3), $urandom_range(0, 3), t[$urandom_range(0, 3)],
                  t[$urandom_range(0, 3)], $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 11) == 0, $urandom_range(0, 1), $urandom_range(0, 7) == 0);
            checks++; if (stall !== exp_stall()) begin errors++; $display("FAIL rnd_stall @%0d: got %b want %b", cyc, stall, exp_stall()); end
            checks++; if (fd_en !== !exp_stall()) begin errors++; $display("FAIL rnd_fd_en @%0d: got %b want %b", cyc, fd_en, !exp_stall()); end
            checks++; if (de_clr !== exp_stall()) begin errors++; $display("FAIL rnd_de_clr @%0d: got %b want %b", cyc, de_clr, exp_stall()); end
            checks++; if (fwd_rs_d !== 2'(exp_fwd_d(int'(rs_d)))) begin errors++; $display("FAIL rnd_fwd_rs_d @%0d: got %0d want %0d", cyc, fwd_rs_d, exp_fwd_d(int'(rs_d))); end
            checks++; if (fwd_rt_d !== 2'(exp_fwd_d(int'(rt_d)))) begin errors++; $display("FAIL rnd_fwd_rt_d @%0d: got %0d want %0d", cyc, fwd_rt_d, exp_fwd_d(int'(rt_d))); end
            checks++; if (fwd_rs_e !== 2'(exp_fwd_e(m_rs))) begin errors++; $display("FAIL rnd_fwd_rs_e @%0d: got %0d want %0d", cyc, fwd_rs_e, exp_fwd_e(m_rs)); end
            checks++; if (fwd_rt_e !== 2'(exp_fwd_e(m_rt))) begin errors++; $display("FAIL rnd_fwd_rt_e @%0d: got %0d want %0d", cyc, fwd_rt_e, exp_fwd_e(m_rt)); end
            checks++; if (md_busy !== exp_busy()) begin errors++; $display("FAIL rnd_md_busy @%0d: got %b want %b", cyc, md_busy, exp_busy()); end
            tick();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_load_use();
        test_alu_branch();
        test_zero_reg();
        test_e_wins();
        test_mdu();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
